// File: rtl/project_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : project_switch_pkg
// Description : Shared types and constants for the project switch controller:
//               FSM state codes, STATUS bit positions and default addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package project_switch_pkg;

   // State codes are visible to software through STATUS[6:4]
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_GATE    = 3'd2,
      ST_RESET   = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   // STATUS register layout
   localparam int c_STAT_BUSY_BIT  = 0;
   localparam int c_STAT_REJ_BIT   = 1;
   localparam int c_STAT_RANGE_BIT = 2;
   localparam int c_STAT_STATE_LSB = 4;
   localparam int c_STAT_SEL_LSB   = 8;

   // Default register addresses at the top of the user address window
   localparam logic [31:0] c_DEF_CFG_ADDRESS    = 32'h300F_FFFC;
   localparam logic [31:0] c_DEF_STATUS_ADDRESS = 32'h300F_FFF8;

endpackage
`default_nettype wire

// File: rtl/project_switch_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : switch_timer
// Description : Loadable down-counter with a zero flag. Shared by the GATE
//               and RESET phases of the project switch sequence. Counts
//               saturate at zero, so a load of N-1 gives a phase of N cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_value,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;

   // Load has priority; otherwise count down and stop at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/project_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : project_switch_ctrl
// Description : Wishbone-configured selector for the multi-project wrapper.
//               Switches the active project by draining the bus, gating the
//               pads, holding every project in reset, then releasing only the
//               newly selected one.
// Revision    : 1.0 - initial release
// ============================================================================
module project_switch_ctrl
   import project_switch_pkg::*;
#(
   parameter int          USER_PROJECTS  = 4,
   parameter int          CFG_BITS       = 2,
   parameter logic [31:0] CFG_ADDRESS    = c_DEF_CFG_ADDRESS,
   parameter logic [31:0] STATUS_ADDRESS = c_DEF_STATUS_ADDRESS,
   parameter int          QUIESCE_CYCLES = 16,
   parameter int          RESET_CYCLES   = 8,
   parameter int          CNT_W          = 8
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_dat_i,
   input  logic [31:0]              wbs_adr_i,
   output logic                     cfg_ack_o,
   output logic [31:0]              cfg_dat_o,
   output logic                     cfg_hit_o,
   output logic [CFG_BITS-1:0]      active_sel_o,
   output logic                     io_gate_o,
   output logic [USER_PROJECTS-1:0] proj_rst_o,
   output logic                     switch_busy_o
);

   localparam int unsigned c_NPROJ_I     = USER_PROJECTS;
   localparam logic [CFG_BITS:0] c_NPROJ = c_NPROJ_I[CFG_BITS:0];
   localparam int unsigned c_QLOAD_I     = QUIESCE_CYCLES - 1;
   localparam int unsigned c_RLOAD_I     = RESET_CYCLES - 1;
   localparam logic [CNT_W-1:0] c_QUIESCE_LOAD = c_QLOAD_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] c_RESET_LOAD   = c_RLOAD_I[CNT_W-1:0];
   localparam logic [USER_PROJECTS-1:0] c_ONE  = USER_PROJECTS'(1);

   state_t                     r_state;
   state_t                     w_state_next;
   logic                       r_ack;
   logic [31:0]                r_dat;
   logic                       r_rejected;
   logic                       r_range_err;
   logic [CFG_BITS-1:0]        r_pending_sel;
   logic [CFG_BITS-1:0]        r_active_sel;
   logic [USER_PROJECTS-1:0]   r_proj_rst;

   logic                       w_is_cfg;
   logic                       w_hit;
   logic                       w_accept;
   logic                       w_wr_en;
   logic                       w_cfg_wr;
   logic                       w_stat_wr;
   logic                       w_idle;
   logic [CFG_BITS-1:0]        w_new_sel;
   logic                       w_in_range;
   logic                       w_start;
   logic [31:0]                w_status;
   logic [31:0]                w_cfg_word;
   logic [USER_PROJECTS-1:0]   w_onehot;
   logic                       w_tmr_load;
   logic [CNT_W-1:0]           w_tmr_value;
   logic                       w_tmr_done;
   logic                       w_commit_sel;
   logic                       w_release;
   logic                       w_unused_bits;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   assign w_is_cfg   = (wbs_adr_i == CFG_ADDRESS);
   assign w_hit      = w_is_cfg || (wbs_adr_i == STATUS_ADDRESS);
   // The !ack term stops a held strobe from being taken twice in a row
   assign w_accept   = wbs_cyc_i && wbs_stb_i && w_hit && !r_ack;
   assign w_wr_en    = w_accept && wbs_we_i && wbs_sel_i[0];
   assign w_cfg_wr   = w_wr_en && w_is_cfg;
   assign w_stat_wr  = w_wr_en && !w_is_cfg;
   assign w_idle     = (r_state == ST_IDLE);
   assign w_new_sel  = wbs_dat_i[CFG_BITS-1:0];
   assign w_in_range = ({1'b0, w_new_sel} < c_NPROJ);
   // Rewriting the current selection still runs the whole sequence (soft reset)
   assign w_start    = w_cfg_wr && w_idle && w_in_range;
   assign w_onehot   = c_ONE << r_active_sel;

   // Only byte lane 0 and the low data bits carry meaning
   assign w_unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i};

   // Assemble the STATUS and CFG read words
   always_comb begin
      w_status                                 = '0;
      w_status[c_STAT_BUSY_BIT]                = !w_idle;
      w_status[c_STAT_REJ_BIT]                 = r_rejected;
      w_status[c_STAT_RANGE_BIT]               = r_range_err;
      w_status[c_STAT_STATE_LSB +: 3]          = r_state;
      w_status[c_STAT_SEL_LSB +: CFG_BITS]     = r_active_sel;
      w_cfg_word                               = '0;
      w_cfg_word[CFG_BITS-1:0]                 = r_active_sel;
   end

   // Registered single-cycle ack with read data captured at accept time
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_accept;
         if (w_accept && !wbs_we_i) begin
            r_dat <= w_is_cfg ? w_cfg_word : w_status;
         end else begin
            r_dat <= '0;
         end
      end
   end

   // Sticky error flags (set by refused CFG writes, W1C via STATUS) and target latch
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_rejected    <= 1'b0;
         r_range_err   <= 1'b0;
         r_pending_sel <= '0;
      end else begin
         if (w_cfg_wr && !w_idle) begin
            r_rejected <= 1'b1;
         end else if (w_stat_wr && wbs_dat_i[c_STAT_REJ_BIT]) begin
            r_rejected <= 1'b0;
         end
         if (w_cfg_wr && w_idle && !w_in_range) begin
            r_range_err <= 1'b1;
         end else if (w_stat_wr && wbs_dat_i[c_STAT_RANGE_BIT]) begin
            r_range_err <= 1'b0;
         end
         if (w_start) begin
            r_pending_sel <= w_new_sel;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Switch sequencer
   // ---------------------------------------------------------------------
   switch_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_value),
      .o_done  (w_tmr_done)
   );

   // State register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and phase-transition strobes
   always_comb begin
      w_state_next = r_state;
      w_tmr_load   = 1'b0;
      w_tmr_value  = '0;
      w_commit_sel = 1'b0;
      w_release    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Wait for the master to finish its bus cycle before gating
            if (!wbs_cyc_i) begin
               w_state_next = ST_GATE;
               w_tmr_load   = 1'b1;
               w_tmr_value  = c_QUIESCE_LOAD;
            end
         end
         ST_GATE: begin
            if (w_tmr_done) begin
               w_state_next = ST_RESET;
               w_tmr_load   = 1'b1;
               w_tmr_value  = c_RESET_LOAD;
               w_commit_sel = 1'b1;
            end
         end
         ST_RESET: begin
            if (w_tmr_done) begin
               w_state_next = ST_RELEASE;
               w_release    = 1'b1;
            end
         end
         ST_RELEASE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Selection and project resets change together, so the mux only moves while all are held
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_active_sel <= '0;
         r_proj_rst   <= ~c_ONE;
      end else if (w_commit_sel) begin
         r_active_sel <= r_pending_sel;
         r_proj_rst   <= '1;
      end else if (w_release) begin
         r_proj_rst   <= ~w_onehot;
      end
   end

   assign cfg_ack_o     = r_ack;
   assign cfg_dat_o     = r_dat;
   assign cfg_hit_o     = w_hit;
   assign active_sel_o  = r_active_sel;
   assign io_gate_o     = !w_idle;
   assign proj_rst_o    = r_proj_rst;
   assign switch_busy_o = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_project_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_project_switch_ctrl
// Description : Scoreboard bench for project_switch_ctrl. A timeline model
//               predicts every ack/read word and the pad/reset outputs each
//               cycle; a monitor compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_project_switch_ctrl;

   localparam int NP = 4;
   localparam int Q  = 16;
   localparam int R  = 8;
   localparam logic [31:0] A_CFG  = 32'h300F_FFFC;
   localparam logic [31:0] A_STAT = 32'h300F_FFF8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat = '0, adr = '0;
   logic        ack, hit, gate, busy;
   logic [31:0] rdat;
   logic [1:0]  asel;
   logic [3:0]  prst;

   // Second instance with three projects, used for range checking
   logic        d3_stb = 1'b0, d3_cyc = 1'b0, d3_we = 1'b0;
   logic [3:0]  d3_sel = 4'h0;
   logic [31:0] d3_dat = '0, d3_adr = '0;
   logic        d3_ack, d3_hit, d3_gate, d3_busy;
   logic [31:0] d3_rdat;
   logic [1:0]  d3_asel;
   logic [2:0]  d3_prst;

   always #5 clk = ~clk;

   project_switch_ctrl #(
      .USER_PROJECTS(4), .CFG_BITS(2), .CFG_ADDRESS(A_CFG), .STATUS_ADDRESS(A_STAT),
      .QUIESCE_CYCLES(Q), .RESET_CYCLES(R), .CNT_W(8)
   ) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .cfg_ack_o(ack), .cfg_dat_o(rdat),
      .cfg_hit_o(hit), .active_sel_o(asel), .io_gate_o(gate), .proj_rst_o(prst),
      .switch_busy_o(busy)
   );

   project_switch_ctrl #(
      .USER_PROJECTS(3), .CFG_BITS(2), .CFG_ADDRESS(A_CFG), .STATUS_ADDRESS(A_STAT),
      .QUIESCE_CYCLES(Q), .RESET_CYCLES(R), .CNT_W(8)
   ) u_dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(d3_stb), .wbs_cyc_i(d3_cyc), .wbs_we_i(d3_we),
      .wbs_sel_i(d3_sel), .wbs_dat_i(d3_dat), .wbs_adr_i(d3_adr), .cfg_ack_o(d3_ack),
      .cfg_dat_o(d3_rdat), .cfg_hit_o(d3_hit), .active_sel_o(d3_asel), .io_gate_o(d3_gate),
      .proj_rst_o(d3_prst), .switch_busy_o(d3_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          e_at;
      bit          rd;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   // Reference model: a switch is a timeline measured from the edge on which
   // the drain ends (cyc seen low): Q gate cycles, R reset cycles, 1 release.
   int   n_edge = 0;
   int   m_sel  = 0, m_pend = 0;
   int   m_acc  = -1, m_dend = -1;
   bit   m_rej  = 0, m_rng = 0, m_ack = 0;
   logic [1:0] e_sel  = 2'd0;
   logic       e_gate = 1'b0;
   logic [3:0] e_rst  = 4'b1110;

   function automatic int phase_after(int e);
      int d;
      if (m_acc < 0) return 0;
      if (m_dend < 0 || e < m_dend) return 1;
      d = e - m_dend;
      if (d < Q) return 2;
      if (d < Q + R) return 3;
      if (d == Q + R) return 4;
      return 0;
   endfunction

   function automatic int sel_after(int e);
      if (m_acc >= 0 && m_dend >= 0 && (e - m_dend) >= Q) return m_pend;
      return m_sel;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model update on every active edge (and immediately on reset)
   initial begin
      int p, s, ph;
      bit acc;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_sel = 0; m_pend = 0; m_acc = -1; m_dend = -1;
            m_rej = 0; m_rng = 0; m_ack = 0;
            sb.delete();
            e_sel = 2'd0; e_gate = 1'b0; e_rst = 4'b1110;
         end else begin
            n_edge++;
            p = phase_after(n_edge - 1);
            if (m_acc >= 0 && p == 0) begin
               m_sel = m_pend; m_acc = -1; m_dend = -1;
            end else if (p == 1 && !cyc) begin
               m_dend = n_edge;
            end
            s   = sel_after(n_edge - 1);
            acc = cyc && stb && (adr == A_CFG || adr == A_STAT) && !m_ack;
            m_ack = acc;
            if (acc) begin
               if (!we) begin
                  sb.push_back('{n_edge, 1'b1, (adr == A_CFG) ? 32'(s) :
                     {20'd0, 4'(s), 1'b0, 3'(p), 1'b0, m_rng, m_rej, (p != 0)}});
               end else begin
                  sb.push_back('{n_edge, 1'b0, 32'd0});
                  if (sel[0] && adr == A_CFG) begin
                     if (p != 0) m_rej = 1;
                     else if (int'(dat[1:0]) >= NP) m_rng = 1;
                     else begin m_pend = int'(dat[1:0]); m_acc = n_edge; m_dend = -1; end
                  end else if (sel[0]) begin
                     if (dat[1]) m_rej = 0;
                     if (dat[2]) m_rng = 0;
                  end
               end
            end
            ph     = phase_after(n_edge);
            e_sel  = 2'(sel_after(n_edge));
            e_gate = (ph != 0);
            e_rst  = (ph == 3) ? 4'b1111 : ~(4'b0001 << sel_after(n_edge));
         end
      end
   end

   // Monitor: compares outputs away from the active edge and pops the scoreboard on ack
   initial begin
      exp_t x;
      bit   exp_ack;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("active_sel", 32'(asel), 32'(e_sel));
            chk("io_gate", 32'(gate), 32'(e_gate));
            chk("busy", 32'(busy), 32'(e_gate));
            chk("proj_rst", 32'(prst), 32'(e_rst));
            chk("cfg_hit", 32'(hit), 32'(adr == A_CFG || adr == A_STAT));
            exp_ack = (sb.size() > 0) && (sb[0].e_at == n_edge);
            chk("cfg_ack", 32'(ack), 32'(exp_ack));
            if (exp_ack) begin
               x = sb.pop_front();
               if (x.rd && ack) chk("read_data", rdat, x.data);
            end
         end
      end
   end

   task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold, input bit keep_cyc);
      bit got;
      got = 0;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         got = ack;
      end
      stb = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
      end
      if (!keep_cyc) begin
         cyc = 0; we = 0;
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk); #1;
         done = (m_acc < 0) && !e_gate;
      end
      chk("idle_timeout", 32'(done), 32'd1);
   endtask

   task automatic d3_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                          output bit got, output logic [31:0] rd);
      got = 0; rd = '0;
      @(posedge clk); #1;
      d3_cyc = 1; d3_stb = 1; d3_we = w; d3_adr = a; d3_dat = d; d3_sel = 4'hF;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         got = d3_ack;
         rd  = d3_rdat;
      end
      d3_cyc = 0; d3_stb = 0; d3_we = 0;
   endtask

   initial begin
      bit          g;
      logic [31:0] r;
      int          k;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      repeat (2) @(posedge clk);

      // Reset state and STATUS after reset
      wb_xfer(0, A_STAT, 0, 4'hF, 0, 0);
      // Full switch to project 2, then confirm with a CFG read
      wb_xfer(1, A_CFG, 32'd2, 4'hF, 0, 0);
      wait_idle();
      wb_xfer(0, A_CFG, 0, 4'hF, 0, 0);
      // Master holds cyc after the write: stays in DRAIN, then a STATUS read inside it
      wb_xfer(1, A_CFG, 32'd1, 4'hF, 20, 1);
      wb_xfer(0, A_STAT, 0, 4'hF, 0, 0);
      wait_idle();
      // CFG write during GATE is refused; original target completes
      wb_xfer(1, A_CFG, 32'd3, 4'hF, 0, 0);
      repeat (4) @(posedge clk);
      wb_xfer(1, A_CFG, 32'd1, 4'hF, 0, 0);
      wait_idle();
      wb_xfer(0, A_CFG, 0, 4'hF, 0, 0);
      wb_xfer(0, A_STAT, 0, 4'hF, 0, 0);
      wb_xfer(1, A_STAT, 32'h2, 4'hF, 0, 0);
      wb_xfer(0, A_STAT, 0, 4'hF, 0, 0);
      // Byte lane 0 disabled: acked, no effect; soft reset of the same project
      wb_xfer(1, A_CFG, 32'd0, 4'hE, 0, 0);
      wb_xfer(1, A_CFG, 32'd3, 4'h1, 0, 0);
      wait_idle();

      // Out-of-range select on the three-project instance
      d3_xfer(1, A_CFG, 32'd3, g, r);
      chk("d3_write_ack", 32'(g), 32'd1);
      d3_xfer(0, A_STAT, 0, g, r);
      chk("d3_status_ack", 32'(g), 32'd1);
      chk("d3_status", r, 32'h0000_0004);
      chk("d3_active_sel", 32'(d3_asel), 32'd0);
      chk("d3_busy", 32'(d3_busy), 32'd0);

      // Randomized traffic
      for (int t = 0; t < 150; t++) begin
         k = $urandom_range(0, 5);
         case (k)
            0: wb_xfer(0, A_CFG, 0, 4'hF, $urandom_range(0, 2), 0);
            1: wb_xfer(0, A_STAT, 0, 4'hF, $urandom_range(0, 2), 0);
            2: wb_xfer(1, A_CFG, $urandom, 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 7) == 0) ? $urandom_range(3, 25) : 0, 0);
            3: wb_xfer(1, A_STAT, $urandom, 4'($urandom_range(0, 15)), 0, 0);
            4: wb_xfer($urandom_range(0, 1) == 1, A_CFG ^ (32'd1 << $urandom_range(0, 31)),
                       $urandom, 4'hF, 0, 0);
            default: repeat ($urandom_range(1, 30)) @(posedge clk);
         endcase
      end
      wait_idle();

      // Asynchronous reset in the middle of the RESET phase
      wb_xfer(1, A_CFG, 32'd3, 4'hF, 0, 0);
      k = 0;
      while (e_rst != 4'b1111 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reach_reset_phase", 32'(e_rst), 32'hF);
      @(posedge clk); #2;
      rst = 1;
      #1;
      chk("rst_active_sel", 32'(asel), 32'd0);
      chk("rst_io_gate", 32'(gate), 32'd0);
      chk("rst_proj_rst", 32'(prst), 32'hE);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      wb_xfer(0, A_STAT, 0, 4'hF, 0, 0);
      wb_xfer(0, A_CFG, 0, 4'hF, 0, 0);
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
